interrupt_arbiter: RTL and testbench
====================================

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter FRAME_INSTR, default 32'h0800_0001, is the instruction word issued for a frame-rate tick.
REQ-002 Parameter JUMP_INSTR, default 32'h0800_0002, is the instruction word issued for a debounced jump press.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable proc_clk cycles needed to accept a jump_key level change.
REQ-004 Port proc_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port jump_key, input, 1: asynchronous raw jump button, high = pressed.
REQ-007 Port frame_rt_clk, input, 1: divided frame-rate clock, treated as asynchronous data; each rising edge is one frame event.
REQ-008 Port interrupt_ack, input, 1: the processor has consumed the presented instruction.
REQ-009 Port interrupt_valid, output, 1: interrupt_instruction holds a valid pending instruction.
REQ-010 Port interrupt_instruction, output, 32: the instruction word to inject; 32'h0 whenever interrupt_valid is low.
REQ-011 Port overrun_count, output, 8: saturating count of frame events lost because one was already pending.

Function
REQ-012 jump_key and frame_rt_clk shall each pass through a 2-flop synchronizer before any other use.
REQ-013 Frame edge: a rising edge of synchronized frame_rt_clk, detected with a registered copy, shall set frame_pend on the following edge. With the FSM IDLE and nothing pending, interrupt_valid is high after the 4th proc_clk edge that sees frame_rt_clk high.
REQ-014 Debounce: the debounced jump level shall change only after synchronized jump_key differs from it for DEBOUNCE_CYCLES consecutive edges. Any agreeing sample clears the counter.
REQ-015 A 0->1 transition of the debounced jump level shall set jump_pend. A 1->0 transition produces no event.
REQ-016 FSM states are IDLE, ISSUE and GAP, encoded 2 bits.
REQ-017 IDLE: if frame_pend is set, go to ISSUE with FRAME_INSTR latched and clear frame_pend. Otherwise, if jump_pend is set, go to ISSUE with JUMP_INSTR latched and clear jump_pend. Otherwise stay in IDLE. Frame always wins when both are pending.
REQ-018 ISSUE: interrupt_valid = 1 and the latched instruction is held stable. On interrupt_ack = 1, go to GAP.
REQ-019 GAP: interrupt_valid = 0 for exactly one cycle, then go to IDLE. Back-to-back grants are therefore spaced by at least 2 idle cycles.
REQ-020 interrupt_ack while not in ISSUE shall be ignored.
REQ-021 A pend flag whose set event and clear (grant) fall in the same cycle shall end set; the new event is kept.
REQ-022 A frame edge arriving while frame_pend is already set shall increment overrun_count, saturating at 8'hFF.
REQ-023 A frame edge arriving while a FRAME_INSTR is in ISSUE or GAP, with frame_pend clear, shall set frame_pend and is not an overrun.
REQ-024 A jump edge arriving while jump_pend is set is discarded and not counted.

Reset
REQ-025 On reset, the following shall be cleared on the next edge:
- state = IDLE
- interrupt_valid = 0, interrupt_instruction = 0
- overrun_count = 0
- both pend flags, all synchronizer flops, edge registers, debounce counter and debounced level = 0
REQ-026 Reset asserted during ISSUE shall drop interrupt_valid on that edge with no ack required. The lost instruction is not reissued.
REQ-027 After reset deasserts, frame_rt_clk or jump_key already high shall be seen as a rising edge, once the synchronizers fill (and, for jump_key, once debounce completes).

Structure
REQ-028 The FSM state encodings and the default FRAME_INSTR/JUMP_INSTR values shall live in the shared controller package used by the IOController blocks.
REQ-029 One sub-module, sync_debounce (2-flop synchronizer, DEBOUNCE_CYCLES filter, rising-edge pulse output), shall be instantiated for jump_key. frame_rt_clk uses the synchronizer and edge-detect path only, with no debounce.
REQ-030 Target size is 120-400 lines of RTL, with no other sub-modules.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Single frame edge, ack held high: valid is high after the 4th edge with instruction 32'h0800_0001, is low one edge after ack, and GAP lasts 1 cycle.
REQ-032 jump_key pulse of 3 cycles gives no interrupt. A pulse held 10 cycles gives exactly one 32'h0800_0002.
REQ-033 Frame and jump pending together: FRAME_INSTR is issued first, then GAP, then JUMP_INSTR.
REQ-034 Ack held low with 3 further frame edges: overrun_count = 2 and, after ack, exactly one more FRAME_INSTR is issued. 300 such edges saturate the count at 8'hFF.
REQ-035 Reset pulsed during ISSUE: valid, instruction and overrun_count read 0 next cycle, and no interrupt follows without new input.

Source files
------------

// File: rtl/interrupt_arbiter_pkg.sv
// Shared controller definitions for the IOController blocks: arbiter FSM
// encodings, default injected instruction words and a saturating counter helper.
package interrupt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam logic [31:0] DEFAULT_FRAME_INSTR = 32'h0800_0001;
  localparam logic [31:0] DEFAULT_JUMP_INSTR  = 32'h0800_0002;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/interrupt_arbiter_sync_debounce.sv
// Two-flop synchronizer followed by a stability filter; emits a one-cycle
// pulse when the filtered level goes from 0 to 1.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          rise_reg;

  // The counter tracks consecutive samples disagreeing with the accepted level;
  // the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      rise_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_reg   <= '0;
        level_reg <= sync_reg[1];
        rise_reg  <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/interrupt_arbiter.sv
// Arbitrates frame-tick and jump-button events into a single instruction
// injection handshake; frame events take priority and lost frames are counted.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter logic [31:0] FRAME_INSTR     = DEFAULT_FRAME_INSTR,
  parameter logic [31:0] JUMP_INSTR      = DEFAULT_JUMP_INSTR,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        proc_clk,
  input  logic        reset,
  input  logic        jump_key,
  input  logic        frame_rt_clk,
  input  logic        interrupt_ack,
  output logic        interrupt_valid,
  output logic [31:0] interrupt_instruction,
  output logic [7:0]  overrun_count
);

  arb_state_t  state_reg, state_next;
  logic [31:0] instr_reg, instr_next;
  logic        frame_pend_reg, frame_pend_next;
  logic        jump_pend_reg, jump_pend_next;
  logic [7:0]  overrun_reg, overrun_next;
  logic [1:0]  frame_sync_reg;
  logic        frame_prev_reg;
  logic        frame_edge;
  logic        jump_edge;
  logic        grant_frame;
  logic        grant_jump;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_jump_debounce (
    .clk (proc_clk),
    .srst(reset),
    .raw (jump_key),
    .rise(jump_edge)
  );

  // Frame ticks are clean, so only synchronize and edge-detect them.
  assign frame_edge = frame_sync_reg[1] & ~frame_prev_reg;

  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    grant_frame = 1'b0;
    grant_jump  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_pend_reg) begin
          state_next  = ST_ISSUE;
          instr_next  = FRAME_INSTR;
          grant_frame = 1'b1;
        end else if (jump_pend_reg) begin
          state_next = ST_ISSUE;
          instr_next = JUMP_INSTR;
          grant_jump = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (interrupt_ack) begin
          state_next = ST_GAP;
        end
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A new event in the same cycle as its grant survives; a frame only counts
  // as lost when the pending one is still waiting.
  always_comb begin
    frame_pend_next = (frame_pend_reg & ~grant_frame) | frame_edge;
    jump_pend_next  = (jump_pend_reg & ~grant_jump) | jump_edge;
    overrun_next    = overrun_reg;
    if (frame_edge && frame_pend_reg && !grant_frame) begin
      overrun_next = sat_inc8(overrun_reg);
    end
  end

  always_ff @(posedge proc_clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      instr_reg      <= '0;
      frame_pend_reg <= 1'b0;
      jump_pend_reg  <= 1'b0;
      overrun_reg    <= '0;
      frame_sync_reg <= '0;
      frame_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      instr_reg      <= instr_next;
      frame_pend_reg <= frame_pend_next;
      jump_pend_reg  <= jump_pend_next;
      overrun_reg    <= overrun_next;
      frame_sync_reg <= {frame_sync_reg[0], frame_rt_clk};
      frame_prev_reg <= frame_sync_reg[1];
    end
  end

  assign interrupt_valid       = (state_reg == ST_ISSUE);
  assign interrupt_instruction = interrupt_valid ? instr_reg : 32'h0;
  assign overrun_count         = overrun_reg;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench for interrupt_arbiter with DEBOUNCE_CYCLES = 4.
module tb_interrupt_arbiter;

  localparam logic [31:0] FRAME_I = 32'h0800_0001;
  localparam logic [31:0] JUMP_I  = 32'h0800_0002;

  logic        proc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        jump_key = 1'b0;
  logic        frame_rt_clk = 1'b0;
  logic        interrupt_ack = 1'b0;
  logic        interrupt_valid;
  logic [31:0] interrupt_instruction;
  logic [7:0]  overrun_count;

  int checks = 0;
  int failures = 0;
  int handshakes = 0;
  logic [31:0] exp_q[$];

  always #5 proc_clk = ~proc_clk;

  interrupt_arbiter #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .proc_clk             (proc_clk),
    .reset                (reset),
    .jump_key             (jump_key),
    .frame_rt_clk         (frame_rt_clk),
    .interrupt_ack        (interrupt_ack),
    .interrupt_valid      (interrupt_valid),
    .interrupt_instruction(interrupt_instruction),
    .overrun_count        (overrun_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: handshakes pop the scoreboard, idle output
  // must be zero, ISSUE must hold its word, grants are spaced by >= 2 cycles.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  int          low_run = 0;
  bit          seen_hs = 1'b0;
  always @(negedge proc_clk) begin
    if (reset) begin
      seen_hs    = 1'b0;
      low_run    = 0;
      prev_valid = 1'b0;
    end else begin
      if (!interrupt_valid) begin
        check_eq("instr_idle_zero", interrupt_instruction, 32'h0);
        low_run++;
      end else begin
        if (!prev_valid && seen_hs) check_eq("gap_at_least_2", 32'(low_run >= 2), 32'h1);
        if (prev_valid) check_eq("instr_stable", interrupt_instruction, prev_instr);
        low_run = 0;
        if (interrupt_ack) begin
          handshakes++;
          seen_hs = 1'b1;
          $display("txn %0d instr=%h overrun=%0d", handshakes, interrupt_instruction, overrun_count);
          if (exp_q.size() == 0) check_eq("grant_expected", 32'(exp_q.size()), 32'h1);
          else check_eq("grant_instr", interrupt_instruction, exp_q.pop_front());
        end
      end
      prev_valid = interrupt_valid;
      prev_instr = interrupt_instruction;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge proc_clk);
      #1;
    end
  endtask

  task automatic frame_pulse();
    frame_rt_clk = 1'b1;
    tick(3);
    frame_rt_clk = 1'b0;
    tick(3);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!interrupt_valid && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("wait_valid_in_budget", 32'(interrupt_valid), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    tick(3);
    check_eq("reset_valid", 32'(interrupt_valid), 32'h0);
    check_eq("reset_instr", interrupt_instruction, 32'h0);
    check_eq("reset_overrun", 32'(overrun_count), 32'h0);
    reset = 1'b0;
    tick(2);

    // Single frame edge with ack held high: valid exactly on edge 4.
    interrupt_ack = 1'b1;
    exp_q.push_back(FRAME_I);
    frame_rt_clk = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check_eq($sformatf("frame_lat_edge%0d", i), 32'(interrupt_valid), 32'(i == 4));
      if (i == 4) check_eq("frame_lat_instr", interrupt_instruction, FRAME_I);
    end
    frame_rt_clk = 1'b0;
    tick(10);
    check_eq("frame_single_drained", 32'(exp_q.size()), 32'h0);

    // Short jump glitch is filtered; a long press yields exactly one jump.
    hs0 = handshakes;
    jump_key = 1'b1;
    tick(3);
    jump_key = 1'b0;
    tick(25);
    check_eq("jump_glitch_none", 32'(handshakes), 32'(hs0));
    exp_q.push_back(JUMP_I);
    jump_key = 1'b1;
    tick(10);
    jump_key = 1'b0;
    tick(30);
    check_eq("jump_press_one", 32'(handshakes), 32'(hs0 + 1));
    check_eq("jump_drained", 32'(exp_q.size()), 32'h0);

    // Both pending while a frame is stalled: frame first, then jump.
    interrupt_ack = 1'b0;
    exp_q.push_back(FRAME_I);
    frame_pulse();
    wait_valid(20);
    jump_key = 1'b1;
    tick(10);
    jump_key = 1'b0;
    exp_q.push_back(FRAME_I);
    exp_q.push_back(JUMP_I);
    frame_pulse();
    tick(10);
    check_eq("pend_in_issue_no_overrun", 32'(overrun_count), 32'h0);
    interrupt_ack = 1'b1;
    tick(30);
    check_eq("priority_drained", 32'(exp_q.size()), 32'h0);

    // Overrun: three more edges while stalled give a count of two.
    interrupt_ack = 1'b0;
    exp_q.push_back(FRAME_I);
    exp_q.push_back(FRAME_I);
    frame_pulse();
    wait_valid(20);
    for (int i = 0; i < 3; i++) frame_pulse();
    check_eq("overrun_two", 32'(overrun_count), 32'h2);
    interrupt_ack = 1'b1;
    tick(20);
    check_eq("overrun_drained", 32'(exp_q.size()), 32'h0);

    interrupt_ack = 1'b0;
    exp_q.push_back(FRAME_I);
    exp_q.push_back(FRAME_I);
    for (int i = 0; i < 300; i++) frame_pulse();
    check_eq("overrun_saturate", 32'(overrun_count), 32'hFF);
    interrupt_ack = 1'b1;
    tick(20);
    check_eq("saturate_drained", 32'(exp_q.size()), 32'h0);

    // Reset during ISSUE drops the instruction without reissue.
    interrupt_ack = 1'b0;
    frame_pulse();
    wait_valid(20);
    reset = 1'b1;
    tick(1);
    check_eq("rst_issue_valid", 32'(interrupt_valid), 32'h0);
    check_eq("rst_issue_instr", interrupt_instruction, 32'h0);
    check_eq("rst_issue_overrun", 32'(overrun_count), 32'h0);
    reset = 1'b0;
    interrupt_ack = 1'b1;
    hs0 = handshakes;
    tick(20);
    check_eq("rst_no_reissue", 32'(handshakes), 32'(hs0));

    // Frame already high through reset is seen as an edge afterwards.
    exp_q.push_back(FRAME_I);
    frame_rt_clk = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(15);
    frame_rt_clk = 1'b0;
    tick(5);
    check_eq("level_after_reset", 32'(handshakes), 32'(hs0 + 1));
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
